memory_arbiter: RTL and testbench

Sequences the single-ported shared RAM between the instruction-fetch port and the data port driven by the control unit's iREN/dREN/dWEN. Sits between the datapath request logic and the RAM model. Data accesses normally win, but a starvation counter guarantees forward progress for fetch. A halt input freezes fetch grants while outstanding data traffic drains.

---
 rtl/memory_arbiter.sv | 164 ++++++++++++++++
 tb/tb_memory_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-ported RAM between instruction fetch and
// data accesses. Data normally wins; a starvation counter forces a fetch grant
// after STARVE_LIMIT consecutive data grants while a fetch was waiting. halt
// blocks new fetch grants while data traffic continues to drain.
//
// Optional feature: define ARB_TIMEOUT_EN to add a per-access RAM timeout that
// parks the arbiter in a sticky error state until reset.
module memory_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT_CYC  = 64
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              halt,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready,
  output logic              err
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
`ifdef ARB_TIMEOUT_EN
    ,
    ERR  = 2'd3
`endif
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     starve_q;
  logic [CW-1:0]     starve_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              op_wr_q;

  logic d_pend;
  logic i_ok;
  logic force_i;
  logic in_iacc;
  logic in_dacc;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TLAST_C = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tcnt_q;
  logic          err_q;
`endif

  // Grant qualifiers evaluated only while IDLE.
  assign d_pend  = dREN | dWEN;
  assign i_ok    = iREN & ~halt;
  assign force_i = i_ok & (starve_q == LIMIT_C);

  // Saturating increment of the starvation counter for a data grant.
  always_comb begin
    starve_d = starve_q;
    if (starve_q != LIMIT_C) begin
      starve_d = starve_q + CW'(1);
    end
  end

  // Arbitration FSM: grants, request latching, starvation and timeout tracking.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      op_wr_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      tcnt_q   <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
`ifdef ARB_TIMEOUT_EN
          tcnt_q <= '0;
`endif
          if (force_i) begin
            state_q  <= IACC;
            addr_q   <= iaddr;
            op_wr_q  <= 1'b0;
            starve_q <= '0;
          end else if (d_pend) begin
            state_q  <= DACC;
            addr_q   <= daddr;
            wdata_q  <= dstore;
            // A write wins when both data strobes are high.
            op_wr_q  <= dWEN;
            starve_q <= i_ok ? starve_d : '0;
          end else if (i_ok) begin
            state_q  <= IACC;
            addr_q   <= iaddr;
            op_wr_q  <= 1'b0;
            starve_q <= '0;
          end
        end
        IACC, DACC: begin
          if (ram_ready) begin
            state_q <= IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (tcnt_q == TLAST_C) begin
            state_q <= ERR;
            err_q   <= 1'b1;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
`endif
        end
`ifdef ARB_TIMEOUT_EN
        ERR: begin
          state_q <= ERR;
        end
`endif
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // RAM-side outputs derive only from state and latched request registers.
  assign in_iacc  = (state_q == IACC);
  assign in_dacc  = (state_q == DACC);
  assign ramREN   = in_iacc | (in_dacc & ~op_wr_q);
  assign ramWEN   = in_dacc & op_wr_q;
  assign ramaddr  = (in_iacc | in_dacc) ? addr_q : '0;
  assign ramstore = (in_dacc & op_wr_q) ? wdata_q : '0;

  // Completion strobes follow ram_ready within the access state.
  assign ihit  = in_iacc & ram_ready;
  assign dhit  = in_dacc & ram_ready;
  assign iload = ihit ? ramload : '0;
  assign dload = (dhit & ~op_wr_q) ? ramload : '0;

`ifdef ARB_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed testbench for memory_arbiter with hand-computed expectations.
module tb_memory_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              CLK;
  logic              nRST;
  logic              halt;
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              ihit;
  logic [DATA_W-1:0] iload;
  logic              dhit;
  logic [DATA_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic              ram_ready;
  logic              err;

  int checks = 0;
  int errors = 0;

  memory_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4), .TIMEOUT_CYC(64)
  ) dut (
    .CLK(CLK), .nRST(nRST), .halt(halt),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle away from it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

  initial begin
    byte exp_seq[10];
    byte got_seq[$];
    int  n_i;
    int  n_d;
    int  bad_addr;
    int  n;

    nRST = 1'b0; halt = 1'b0; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
    daddr = '0; dstore = '0; ramload = '0; ram_ready = 1'b0;
    tick();
    tick();
    check("rst_ramREN", ramREN, 0);
    check("rst_ramWEN", ramWEN, 0);
    check("rst_ramaddr", ramaddr, 0);
    check("rst_ihit", ihit, 0);
    check("rst_dhit", dhit, 0);
    check("rst_err", err, 0);

    // Single fetch, RAM ready in the cycle after the request.
    nRST = 1'b1; iREN = 1'b1; iaddr = 32'h40; ramload = 32'h2408000A; ram_ready = 1'b1;
    tick();
    check("f1_ramREN", ramREN, 1);
    check("f1_ramWEN", ramWEN, 0);
    check("f1_ramaddr", ramaddr, 32'h40);
    check("f1_ihit", ihit, 1);
    check("f1_iload", iload, 32'h2408000A);
    iREN = 1'b0;
    tick();
    check("f1_idle_ihit", ihit, 0);
    check("f1_idle_ramREN", ramREN, 0);

    // Simultaneous fetch and write (with dREN too): write goes first.
    iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; dREN = 1'b1;
    daddr = 32'h80; dstore = 32'hDEADBEEF; ramload = 32'h11112222;
    tick();
    check("w_ramWEN", ramWEN, 1);
    check("w_ramREN", ramREN, 0);
    check("w_ramaddr", ramaddr, 32'h80);
    check("w_ramstore", ramstore, 32'hDEADBEEF);
    check("w_dhit", dhit, 1);
    check("w_dload", dload, 0);
    check("w_ihit", ihit, 0);
    dWEN = 1'b0; dREN = 1'b0;
    tick();
    check("w_gap_ramREN", ramREN, 0);
    check("w_gap_ramWEN", ramWEN, 0);
    tick();
    check("w_fetch_ihit", ihit, 1);
    check("w_fetch_ramaddr", ramaddr, 32'h44);
    check("w_fetch_iload", iload, 32'h11112222);
    iREN = 1'b0;
    tick();

    // Starvation: dREN held with iREN pending -> 4 data, 1 fetch, repeat.
    exp_seq = '{"d", "d", "d", "d", "i", "d", "d", "d", "d", "i"};
    dREN = 1'b1; iREN = 1'b1; daddr = 32'h100; iaddr = 32'h200; ramload = 32'hCAFE0001;
    bad_addr = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (dhit) begin
        got_seq.push_back("d");
        if (ramaddr != 32'h100 || dload != 32'hCAFE0001) bad_addr++;
      end
      if (ihit) begin
        got_seq.push_back("i");
        if (ramaddr != 32'h200 || iload != 32'hCAFE0001) bad_addr++;
      end
      if (c == 19) begin
        dREN = 1'b0; iREN = 1'b0;
      end
    end
    check("starve_nhits", got_seq.size(), 10);
    for (int k = 0; k < 10; k++) begin
      if (k < got_seq.size()) check($sformatf("starve_seq%0d", k), got_seq[k], exp_seq[k]);
      else check($sformatf("starve_seq%0d", k), 0, exp_seq[k]);
    end
    check("starve_addr_data", bad_addr, 0);
    tick();

    // halt: only data grants, fetch never served.
    halt = 1'b1; iREN = 1'b1; dREN = 1'b1; daddr = 32'h300; iaddr = 32'h400;
    n_i = 0; n_d = 0; bad_addr = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (ihit) n_i++;
      if (dhit) n_d++;
      if (ramREN && ramaddr != 32'h300) bad_addr++;
    end
    check("halt_ihits", n_i, 0);
    check("halt_dhits", n_d, 6);
    check("halt_addr", bad_addr, 0);
    dREN = 1'b0; iREN = 1'b0; halt = 1'b0;
    tick();

    // halt raised during a fetch: it completes, then no new fetch grant.
    ram_ready = 1'b0; iREN = 1'b1; iaddr = 32'h48;
    tick();
    halt = 1'b1; ram_ready = 1'b1;
    #1;
    check("halt_mid_ihit", ihit, 1);
    tick();
    tick();
    check("halt_after_ramREN", ramREN, 0);
    check("halt_after_ihit", ihit, 0);
    halt = 1'b0; iREN = 1'b0;
    tick();

    // Reset during a stalled data read; inputs ignored mid-access.
    ram_ready = 1'b0; dREN = 1'b1; daddr = 32'h500;
    tick();
    check("rd_stall_ramREN", ramREN, 1);
    check("rd_stall_dhit", dhit, 0);
    daddr = 32'h600;
    tick();
    check("rd_stall_hold_addr", ramaddr, 32'h500);
    nRST = 1'b0;
    tick();
    check("midrst_ramREN", ramREN, 0);
    check("midrst_ramaddr", ramaddr, 0);
    check("midrst_dhit", dhit, 0);
    nRST = 1'b1; ram_ready = 1'b1; ramload = 32'h12345678;
    tick();
    check("postrst_dhit", dhit, 1);
    check("postrst_ramaddr", ramaddr, 32'h600);
    check("postrst_dload", dload, 32'h12345678);
    dREN = 1'b0;
    tick();
    check("postrst_err", err, 0);

`ifdef ARB_TIMEOUT_EN
    // RAM never ready: error after 64 access cycles, sticky until reset.
    ram_ready = 1'b0; iREN = 1'b1; iaddr = 32'h80;
    tick();
    iREN = 1'b0;
    n = 0;
    while (ramREN && n < 200) begin
      n++;
      tick();
    end
    check("to_cycles", n, 64);
    check("to_err", err, 1);
    check("to_ramREN", ramREN, 0);
    ram_ready = 1'b1; dREN = 1'b1;
    tick();
    tick();
    check("to_sticky_err", err, 1);
    check("to_no_dhit", dhit, 0);
    check("to_no_ramREN", ramREN, 0);
    dREN = 1'b0; nRST = 1'b0;
    tick();
    check("to_rst_err", err, 0);
    nRST = 1'b1;
    tick();
`else
    // Without the timeout, a long stall just keeps waiting.
    ram_ready = 1'b0; iREN = 1'b1; iaddr = 32'h80;
    tick();
    iREN = 1'b0;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      if (ramREN) n++;
      tick();
    end
    check("nto_wait_cycles", n, 100);
    check("nto_err", err, 0);
    ram_ready = 1'b1;
    #1;
    check("nto_late_ihit", ihit, 1);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
